// File: rtl/keypad_lock_ctrl.sv
// Multi-digit keypad lock: collects a code, compares it on enter, grants timed access,
// counts consecutive failures into a timed alarm lockout and allows reprogramming while open.
module keypad_lock_ctrl #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 16'h1234
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             digit_valid,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             enter,
    input  logic                             clear,
    input  logic                             prog_en,
    output logic                             access,
    output logic                             alarm,
    output logic                             denied,
    output logic                             pass_updated,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int BUF_W   = DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

    state_t             state, state_n;
    logic [BUF_W-1:0]   buffer, buffer_n;
    logic [BUF_W-1:0]   password, password_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               ovf, ovf_n;
    logic [FAIL_W-1:0]  fail_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic               denied_n, updated_n;
    logic               entry_ok;

    assign entry_ok = (cnt == CNT_W'(DIGITS)) && !ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            buffer       <= '0;
            password     <= DEFAULT_PASS;
            cnt          <= '0;
            ovf          <= 1'b0;
            fail_count   <= '0;
            timer        <= '0;
            denied       <= 1'b0;
            pass_updated <= 1'b0;
        end else begin
            state        <= state_n;
            buffer       <= buffer_n;
            password     <= password_n;
            cnt          <= cnt_n;
            ovf          <= ovf_n;
            fail_count   <= fail_n;
            timer        <= timer_n;
            denied       <= denied_n;
            pass_updated <= updated_n;
        end
    end

    // Priority within a cycle is clear, then enter, then digit_valid; the open timer
    // is applied last so an expiring cycle still completes a programming request.
    always_comb begin
        state_n    = state;
        buffer_n   = buffer;
        password_n = password;
        cnt_n      = cnt;
        ovf_n      = ovf;
        fail_n     = fail_count;
        timer_n    = timer;
        denied_n   = 1'b0;
        updated_n  = 1'b0;

        case (state)
            IDLE, OPEN: begin
                if (clear) begin
                    buffer_n = '0;
                    cnt_n    = '0;
                    ovf_n    = 1'b0;
                end else if (enter) begin
                    buffer_n = '0;
                    cnt_n    = '0;
                    ovf_n    = 1'b0;
                    if (state == IDLE) begin
                        if (entry_ok && (buffer == password)) begin
                            state_n = OPEN;
                            fail_n  = '0;
                            timer_n = TMR_W'(UNLOCK_CYCLES);
                        end else begin
                            denied_n = 1'b1;
                            fail_n   = fail_count + FAIL_W'(1);
                            if (fail_n == FAIL_W'(MAX_TRIES)) begin
                                state_n = LOCKOUT;
                                timer_n = TMR_W'(LOCKOUT_CYCLES);
                            end
                        end
                    end else if (prog_en && entry_ok) begin
                        password_n = buffer;
                        updated_n  = 1'b1;
                    end
                end else if (digit_valid) begin
                    buffer_n = (buffer << DIGIT_W) | BUF_W'(digit);
                    if (cnt == CNT_W'(DIGITS)) begin
                        ovf_n = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end

                if (state == OPEN) begin
                    if (timer == TMR_W'(1)) begin
                        state_n  = IDLE;
                        timer_n  = '0;
                        buffer_n = '0;
                        cnt_n    = '0;
                        ovf_n    = 1'b0;
                    end else begin
                        timer_n = timer - TMR_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (timer == TMR_W'(1)) begin
                    state_n = IDLE;
                    timer_n = '0;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign access = (state == OPEN);
    assign alarm  = (state == LOCKOUT);

endmodule
